// File: rtl/motor_command_sequencer_pkg.sv
// Shared definitions for the motor sequencer: direction codes (common with tone
// detection), sequencer state encoding and small decode helpers.
package motor_command_sequencer_pkg;

    typedef enum logic [2:0] {
        DIR_STRAIGHT = 3'b000,
        DIR_LEFT     = 3'b001,
        DIR_RIGHT    = 3'b010,
        DIR_BACK     = 3'b011,
        DIR_STOP     = 3'b100
    } dir_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEADTIME,
        ST_TURN,
        ST_SPIN,
        ST_CRUISE
    } seq_state_e;

    // Every code with bit 2 set collapses to STOP so 100/101/110/111 never differ.
    function automatic dir_code_e normalize_dir(input logic [2:0] code);
        return code[2] ? DIR_STOP : dir_code_e'(code);
    endfunction

    function automatic seq_state_e manoeuvre_for(input dir_code_e code);
        case (code)
            DIR_LEFT, DIR_RIGHT: return ST_TURN;
            DIR_BACK:            return ST_SPIN;
            default:             return ST_CRUISE;
        endcase
    endfunction

endpackage

// File: rtl/motor_command_sequencer_if.sv
// Command input and H-bridge drive signals of the motor sequencer.
interface motor_command_sequencer_if;
    logic [2:0] tdDIR;
    logic       motL_pwm;
    logic       motL_dir;
    logic       motR_pwm;
    logic       motR_dir;
    logic       busy;

    modport master (output tdDIR, input motL_pwm, motL_dir, motR_pwm, motR_dir, busy);
    modport slave  (input tdDIR, output motL_pwm, motL_dir, motR_pwm, motR_dir, busy);
endinterface

// File: rtl/motor_command_sequencer_pwm_gen.sv
// Free-running PWM counter shared by both motors, with one duty compare and
// enable per motor.
module motor_command_sequencer_pwm_gen #(
    parameter  int PWM_PERIOD = 2500,
    localparam int CNT_W      = $clog2(PWM_PERIOD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             l_en,
    input  logic [CNT_W-1:0] l_duty,
    input  logic             r_en,
    input  logic [CNT_W-1:0] r_duty,
    output logic             l_pwm,
    output logic             r_pwm
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_W'(PWM_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Counter never reaches PWM_PERIOD, so a duty at or above it is constant high.
    assign l_pwm = l_en && (cnt_q < l_duty);
    assign r_pwm = r_en && (cnt_q < r_duty);

endmodule

// File: rtl/motor_command_sequencer.sv
// Motor command sequencer: turns direction-code changes into timed manoeuvres
// (dead-time, pivot turn or spin, cruise) on the left/right H-bridges.
module motor_command_sequencer
    import motor_command_sequencer_pkg::*;
#(
    parameter int PWM_PERIOD  = 2500,
    parameter int DUTY_CRUISE = 1750,
    parameter int DUTY_TURN   = 1250,
    parameter int DEAD_CYCLES = 50_000,
    parameter int TURN_CYCLES = 25_000_000,
    parameter int BACK_CYCLES = 50_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    motor_command_sequencer_if.slave bus
);
    localparam int PWM_W   = $clog2(PWM_PERIOD + 1);
    localparam int TB_MAX  = (TURN_CYCLES > BACK_CYCLES) ? TURN_CYCLES : BACK_CYCLES;
    localparam int MAN_MAX = (TB_MAX > DEAD_CYCLES) ? TB_MAX : DEAD_CYCLES;
    localparam int MAN_W   = $clog2(MAN_MAX + 1);

    localparam logic [PWM_W-1:0] CRUISE_DUTY =
        PWM_W'((DUTY_CRUISE >= PWM_PERIOD) ? PWM_PERIOD : DUTY_CRUISE);
    localparam logic [PWM_W-1:0] TURN_DUTY =
        PWM_W'((DUTY_TURN >= PWM_PERIOD) ? PWM_PERIOD : DUTY_TURN);
    localparam logic [MAN_W-1:0] DEAD_LAST = MAN_W'(DEAD_CYCLES - 1);
    localparam logic [MAN_W-1:0] TURN_LAST = MAN_W'(TURN_CYCLES - 1);
    localparam logic [MAN_W-1:0] BACK_LAST = MAN_W'(BACK_CYCLES - 1);

    dir_code_e        cmd_q, cmd_d, last_cmd_q, last_cmd_d;
    dir_code_e        target_q, target_d, pending_q, pending_d;
    seq_state_e       state_q, state_d;
    logic             pending_valid_q, pending_valid_d;
    logic [MAN_W-1:0] man_cnt_q, man_cnt_d;
    logic             busy_q, busy_d, en_q, en_d;
    logic             l_dir_q, l_dir_d, r_dir_q, r_dir_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic             cmd_event, man_done;
    logic             l_pwm, r_pwm;

    always_comb begin
        cmd_d           = normalize_dir(bus.tdDIR);
        last_cmd_d      = cmd_q;
        cmd_event       = (cmd_q != last_cmd_q);
        state_d         = state_q;
        target_d        = target_q;
        pending_valid_d = pending_valid_q;
        pending_d       = pending_q;
        man_cnt_d       = (man_cnt_q == '1) ? man_cnt_q : man_cnt_q + 1'b1;
        man_done        = 1'b0;

        case (state_q)
            ST_DEADTIME: man_done = (man_cnt_q == DEAD_LAST);
            ST_TURN:     man_done = (man_cnt_q == TURN_LAST);
            ST_SPIN:     man_done = (man_cnt_q == BACK_LAST);
            default:     man_done = 1'b0;
        endcase

        // A new command beats a manoeuvre ending in the same cycle.
        if (cmd_event && cmd_q == DIR_STOP) begin
            state_d         = ST_IDLE;
            pending_valid_d = 1'b0;
        end else if (cmd_event && (state_q == ST_TURN || state_q == ST_SPIN) && !man_done) begin
            pending_valid_d = 1'b1;
            pending_d       = cmd_q;
        end else if (cmd_event) begin
            state_d         = ST_DEADTIME;
            target_d        = cmd_q;
            pending_valid_d = 1'b0;
            man_cnt_d       = '0;
        end else if (man_done) begin
            man_cnt_d = '0;
            if (state_q == ST_DEADTIME) begin
                state_d = manoeuvre_for(target_q);
            end else if (pending_valid_q) begin
                state_d         = ST_DEADTIME;
                target_d        = pending_q;
                pending_valid_d = 1'b0;
            end else begin
                state_d = ST_CRUISE;
            end
        end

        busy_d  = (state_d == ST_DEADTIME) || (state_d == ST_TURN) || (state_d == ST_SPIN);
        l_dir_d = l_dir_q;
        r_dir_d = r_dir_q;
        en_d    = 1'b0;
        duty_d  = '0;
        case (state_d)
            ST_IDLE: begin
                l_dir_d = 1'b0;
                r_dir_d = 1'b0;
            end
            ST_TURN: begin
                l_dir_d = (target_d == DIR_RIGHT);
                r_dir_d = (target_d != DIR_RIGHT);
                en_d    = 1'b1;
                duty_d  = TURN_DUTY;
            end
            ST_SPIN: begin
                l_dir_d = 1'b0;
                r_dir_d = 1'b1;
                en_d    = 1'b1;
                duty_d  = TURN_DUTY;
            end
            ST_CRUISE: begin
                l_dir_d = 1'b1;
                r_dir_d = 1'b1;
                en_d    = 1'b1;
                duty_d  = CRUISE_DUTY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q           <= DIR_STOP;
            last_cmd_q      <= DIR_STOP;
            state_q         <= ST_IDLE;
            target_q        <= DIR_STOP;
            pending_valid_q <= 1'b0;
            pending_q       <= DIR_STOP;
            man_cnt_q       <= '0;
            busy_q          <= 1'b0;
            l_dir_q         <= 1'b0;
            r_dir_q         <= 1'b0;
            en_q            <= 1'b0;
            duty_q          <= '0;
        end else begin
            cmd_q           <= cmd_d;
            last_cmd_q      <= last_cmd_d;
            state_q         <= state_d;
            target_q        <= target_d;
            pending_valid_q <= pending_valid_d;
            pending_q       <= pending_d;
            man_cnt_q       <= man_cnt_d;
            busy_q          <= busy_d;
            l_dir_q         <= l_dir_d;
            r_dir_q         <= r_dir_d;
            en_q            <= en_d;
            duty_q          <= duty_d;
        end
    end

    motor_command_sequencer_pwm_gen #(.PWM_PERIOD(PWM_PERIOD)) u_pwm_gen (
        .clk    (clk),
        .rst    (rst),
        .l_en   (en_q),
        .l_duty (duty_q),
        .r_en   (en_q),
        .r_duty (duty_q),
        .l_pwm  (l_pwm),
        .r_pwm  (r_pwm)
    );

    assign bus.motL_pwm = l_pwm;
    assign bus.motR_pwm = r_pwm;
    assign bus.motL_dir = l_dir_q;
    assign bus.motR_dir = r_dir_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_motor_command_sequencer.sv
// Scoreboard bench for motor_command_sequencer with shortened timing parameters;
// each scenario queues the per-cycle outputs it expects and drains them.
module tb_motor_command_sequencer;

    typedef struct {
        bit busy;
        int duty;
        bit l_dir;
        bit r_dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;
    int   ph         = 0;
    exp_t sb[$];

    motor_command_sequencer_if dut_if();

    motor_command_sequencer #(
        .PWM_PERIOD  (10),
        .DUTY_CRUISE (7),
        .DUTY_TURN   (5),
        .DEAD_CYCLES (4),
        .TURN_CYCLES (20),
        .BACK_CYCLES (40)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    always #5 clk = ~clk;

    // Reference PWM phase: 0..9, cleared by reset, untouched by commands.
    always @(posedge clk) begin
        if (rst) ph <= 0;
        else     ph <= (ph == 9) ? 0 : ph + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input bit busy, input int duty, input bit l_dir, input bit r_dir);
        exp_t e;
        e.busy  = busy;
        e.duty  = duty;
        e.l_dir = l_dir;
        e.r_dir = r_dir;
        repeat (n) sb.push_back(e);
    endtask

    function automatic logic [4:0] expand(input exp_t e, input int phase);
        logic pwm;
        pwm = (phase < e.duty);
        return {e.busy, pwm, e.l_dir, pwm, e.r_dir};
    endfunction

    function automatic logic [4:0] observed();
        return {dut_if.busy, dut_if.motL_pwm, dut_if.motL_dir, dut_if.motR_pwm, dut_if.motR_dir};
    endfunction

    task automatic test_reset();
        logic [4:0] obs, exp_v;
        exp_t e;
        int i = 0;
        dut_if.tdDIR = 3'b100;
        rst = 1'b1;
        push_n(103, 0, 0, 0, 0);
        while (sb.size() > 0) begin
            step();
            i++;
            e = sb.pop_front();
            exp_v = expand(e, ph);
            obs = observed();
            compared++;
            if (obs !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL reset cycle+%0d: got %b required %b", i, obs, exp_v);
            end
            if (i == 3) rst = 1'b0;
        end
    endtask

    task automatic test_straight();
        logic [4:0] obs, exp_v;
        exp_t e;
        int i = 0;
        dut_if.tdDIR = 3'b000;
        push_n(1, 0, 0, 0, 0);
        push_n(4, 1, 0, 0, 0);
        push_n(30, 0, 7, 1, 1);
        while (sb.size() > 0) begin
            step();
            i++;
            e = sb.pop_front();
            exp_v = expand(e, ph);
            obs = observed();
            compared++;
            if (obs !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL straight cycle+%0d: got %b required %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_turn();
        logic [4:0] obs, exp_v;
        exp_t e;
        int i = 0;
        dut_if.tdDIR = 3'b001;
        push_n(1, 0, 7, 1, 1);
        push_n(4, 1, 0, 1, 1);
        push_n(20, 1, 5, 0, 1);
        push_n(10, 0, 7, 1, 1);
        while (sb.size() > 0) begin
            step();
            i++;
            e = sb.pop_front();
            exp_v = expand(e, ph);
            obs = observed();
            compared++;
            if (obs !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL turn cycle+%0d: got %b required %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_pending();
        logic [4:0] obs, exp_v;
        exp_t e;
        int i = 0;
        dut_if.tdDIR = 3'b011;
        push_n(1, 0, 7, 1, 1);
        push_n(4, 1, 0, 1, 1);
        push_n(40, 1, 5, 0, 1);
        push_n(4, 1, 0, 0, 1);
        push_n(20, 1, 5, 0, 1);
        push_n(10, 0, 7, 1, 1);
        while (sb.size() > 0) begin
            step();
            i++;
            e = sb.pop_front();
            exp_v = expand(e, ph);
            obs = observed();
            compared++;
            if (obs !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL pending cycle+%0d: got %b required %b", i, obs, exp_v);
            end
            if (i == 12) dut_if.tdDIR = 3'b010;
            if (i == 17) dut_if.tdDIR = 3'b001;
        end
    endtask

    task automatic test_collision();
        logic [4:0] obs, exp_v;
        exp_t e;
        int i = 0;
        dut_if.tdDIR = 3'b010;
        push_n(1, 0, 7, 1, 1);
        push_n(4, 1, 0, 1, 1);
        push_n(20, 1, 5, 1, 0);
        push_n(4, 1, 0, 1, 0);
        push_n(10, 0, 7, 1, 1);
        while (sb.size() > 0) begin
            step();
            i++;
            e = sb.pop_front();
            exp_v = expand(e, ph);
            obs = observed();
            compared++;
            if (obs !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL collision cycle+%0d: got %b required %b", i, obs, exp_v);
            end
            if (i == 24) dut_if.tdDIR = 3'b000;
        end
    endtask

    task automatic test_stop();
        logic [4:0] obs, exp_v;
        logic [2:0] stop_codes [3];
        exp_t e;
        int i;
        stop_codes[0] = 3'b100;
        stop_codes[1] = 3'b101;
        stop_codes[2] = 3'b111;
        i = 0;
        dut_if.tdDIR = 3'b100;
        push_n(1, 0, 7, 1, 1);
        push_n(10, 0, 0, 0, 0);
        while (sb.size() > 0) begin
            step();
            i++;
            e = sb.pop_front();
            exp_v = expand(e, ph);
            obs = observed();
            compared++;
            if (obs !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL stop_cruise cycle+%0d: got %b required %b", i, obs, exp_v);
            end
        end
        for (int k = 0; k < 3; k++) begin
            i = 0;
            dut_if.tdDIR = 3'b001;
            push_n(1, 0, 0, 0, 0);
            push_n(4, 1, 0, 0, 0);
            push_n(6, 1, 5, 0, 1);
            push_n(10, 0, 0, 0, 0);
            while (sb.size() > 0) begin
                step();
                i++;
                e = sb.pop_front();
                exp_v = expand(e, ph);
                obs = observed();
                compared++;
                if (obs !== exp_v) begin
                    mismatched++;
                    $display("[TB] FAIL stop_%b cycle+%0d: got %b required %b", stop_codes[k], i, obs, exp_v);
                end
                if (i == 10) dut_if.tdDIR = stop_codes[k];
            end
        end
    endtask

    task automatic test_reset_mid_spin();
        logic [4:0] obs, exp_v;
        exp_t e;
        int i = 0;
        dut_if.tdDIR = 3'b011;
        push_n(1, 0, 0, 0, 0);
        push_n(4, 1, 0, 0, 0);
        push_n(15, 1, 5, 0, 1);
        push_n(3, 0, 0, 0, 0);
        push_n(4, 1, 0, 0, 0);
        push_n(20, 1, 5, 0, 1);
        push_n(10, 0, 7, 1, 1);
        while (sb.size() > 0) begin
            step();
            i++;
            e = sb.pop_front();
            exp_v = expand(e, ph);
            obs = observed();
            compared++;
            if (obs !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL reset_mid_spin cycle+%0d: got %b required %b", i, obs, exp_v);
            end
            if (i == 10) dut_if.tdDIR = 3'b001;
            if (i == 20) rst = 1'b1;
            if (i == 22) rst = 1'b0;
        end
    endtask

    initial begin
        dut_if.tdDIR = 3'b100;
        test_reset();
        test_straight();
        test_turn();
        test_pending();
        test_collision();
        test_stop();
        test_reset_mid_spin();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run still active at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
